// File: rtl/player_damage_controller.sv
// Player damage life-cycle: per-frame collision latch, lives, invincibility and blink.
// Optional extra-life pickup input enabled by defining PLAYER_EXTRA_LIFE_EN.
module player_damage_controller #(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned INV_FRAMES   = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic       clock_100mhz,
  input  logic       reset_n,
  input  logic       game_active,
  input  logic       game_start,
  input  logic       frame_tick,
  input  logic       collision_pixel,
`ifdef PLAYER_EXTRA_LIFE_EN
  input  logic       extra_life_pickup,
`endif
  output logic       player_is_invincible,
  output logic       player_visible,
  output logic [2:0] lives,
  output logic       hit_event,
  output logic       game_over
);

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned CNT_W   = 8;

  localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX   = LIVES_W'(7);
  localparam logic [CNT_W-1:0]   INV_LOAD    = CNT_W'(INV_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_LOAD  = CNT_W'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ALIVE      = 2'd1,
    INVINCIBLE = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  state_t             state;
  logic               hit_latch;
  logic [CNT_W-1:0]   inv_cnt;
  logic [CNT_W-1:0]   blink_cnt;

  logic               pickup_c;
  logic               frame_hit_c;
  logic [LIVES_W-1:0] lives_inc_c;
  logic [LIVES_W-1:0] lives_hit_c;
  logic [CNT_W-1:0]   inv_dec_c;
  logic [CNT_W-1:0]   blink_dec_c;

`ifdef PLAYER_EXTRA_LIFE_EN
  assign pickup_c = extra_life_pickup && ((state == ALIVE) || (state == INVINCIBLE));
`else
  assign pickup_c = 1'b0;
`endif

  // A collision in the tick cycle still belongs to the frame that is ending.
  assign frame_hit_c = hit_latch | collision_pixel;

  // Saturating lives arithmetic; a pickup coinciding with a hit cancels it out.
  assign lives_inc_c = (lives == LIVES_MAX) ? LIVES_MAX : lives + LIVES_W'(1);
  assign lives_hit_c = pickup_c ? lives :
                       ((lives == '0) ? '0 : lives - LIVES_W'(1));

  // Frame counters never wrap below zero.
  assign inv_dec_c   = (inv_cnt == '0)   ? '0 : inv_cnt - CNT_W'(1);
  assign blink_dec_c = (blink_cnt == '0) ? '0 : blink_cnt - CNT_W'(1);

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      lives                <= '0;
      player_is_invincible <= 1'b0;
      player_visible       <= 1'b1;
      hit_event            <= 1'b0;
      game_over            <= 1'b0;
      inv_cnt              <= '0;
      blink_cnt            <= '0;
      hit_latch            <= 1'b0;
    end else begin
      hit_event <= 1'b0;
      if (!game_active) begin
        state                <= IDLE;
        player_is_invincible <= 1'b0;
        player_visible       <= 1'b1;
        game_over            <= 1'b0;
        inv_cnt              <= '0;
        blink_cnt            <= '0;
        hit_latch            <= 1'b0;
      end else if (game_start) begin
        state                <= ALIVE;
        lives                <= LIVES_START;
        player_is_invincible <= 1'b0;
        player_visible       <= 1'b1;
        game_over            <= 1'b0;
        inv_cnt              <= '0;
        blink_cnt            <= '0;
        hit_latch            <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            hit_latch <= 1'b0;
          end
          ALIVE: begin
            if (frame_tick) begin
              hit_latch <= 1'b0;
              if (frame_hit_c) begin
                hit_event <= 1'b1;
                if (lives_hit_c == '0) begin
                  state     <= GAME_OVER;
                  lives     <= '0;
                  game_over <= 1'b1;
                end else begin
                  state                <= INVINCIBLE;
                  lives                <= lives_hit_c;
                  inv_cnt              <= INV_LOAD;
                  blink_cnt            <= BLINK_LOAD;
                  player_visible       <= 1'b0;
                  player_is_invincible <= 1'b1;
                end
              end else if (pickup_c) begin
                lives <= lives_inc_c;
              end
            end else begin
              hit_latch <= frame_hit_c;
              if (pickup_c) lives <= lives_inc_c;
            end
          end
          INVINCIBLE: begin
            hit_latch <= 1'b0;
            if (pickup_c) lives <= lives_inc_c;
            if (frame_tick) begin
              if (inv_dec_c == '0) begin
                state                <= ALIVE;
                inv_cnt              <= '0;
                blink_cnt            <= '0;
                player_is_invincible <= 1'b0;
                player_visible       <= 1'b1;
              end else begin
                inv_cnt <= inv_dec_c;
                if (blink_dec_c == '0) begin
                  player_visible <= ~player_visible;
                  blink_cnt      <= BLINK_LOAD;
                end else begin
                  blink_cnt <= blink_dec_c;
                end
              end
            end
          end
          GAME_OVER: begin
            hit_latch      <= 1'b0;
            lives          <= '0;
            game_over      <= 1'b1;
            player_visible <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
